// File: rtl/sram_stage_sequencer.sv
// sram_stage_sequencer: runs UART load -> M1 conversion -> VGA display in order,
// hands the external SRAM bus to exactly one stage at a time with a
// write-inhibited guard gap between owners, times out hung stages and reports
// the RUN length of each completed stage.
module sram_stage_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Go,
    output logic        Load_start,
    output logic        M1_start,
    output logic        Disp_start,
    input  logic        Load_stop,
    input  logic        M1_stop,
    input  logic [17:0] Load_address,
    input  logic [17:0] M1_address,
    input  logic [17:0] Disp_address,
    input  logic [15:0] Load_write_data,
    input  logic [15:0] M1_write_data,
    input  logic        Load_we_n,
    input  logic        M1_we_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [1:0]  Stage,
    output logic        Error,
    output logic [31:0] Last_stage_cycles
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_GUARD, S_LOAD_START, S_LOAD_RUN,
        S_M1_GUARD, S_M1_START, S_M1_RUN,
        S_DISP_GUARD, S_DISP_START, S_DISP_RUN, S_ERROR
    } state_t;

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] wdata;
        logic        we_n;
    } sram_bus_t;

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    state_t        state, state_n;
    logic          go_q, go_rise;
    logic [GW-1:0] guard_cnt;
    logic [31:0]   run_cnt, run_inc;
    logic          in_guard, in_run, stop_seen;
    sram_bus_t     bus;

    function automatic logic [1:0] stage_of(input state_t s);
        case (s)
            S_LOAD_GUARD, S_LOAD_START, S_LOAD_RUN: stage_of = 2'd1;
            S_M1_GUARD, S_M1_START, S_M1_RUN:       stage_of = 2'd2;
            S_DISP_GUARD, S_DISP_START, S_DISP_RUN: stage_of = 2'd3;
            default:                                stage_of = 2'd0;
        endcase
    endfunction

    assign go_rise   = Go & ~go_q;
    assign in_guard  = (state == S_LOAD_GUARD) || (state == S_M1_GUARD) || (state == S_DISP_GUARD);
    assign in_run    = (state == S_LOAD_RUN) || (state == S_M1_RUN) || (state == S_DISP_RUN);
    // Saturating increment; the same value feeds the timeout compare and the cycle report.
    assign run_inc   = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
    // Stop levels only count inside their own RUN state, so a stale level is harmless.
    assign stop_seen = ((state == S_LOAD_RUN) && Load_stop) || ((state == S_M1_RUN) && M1_stop);

    // Next-state logic: fixed stage order, stop beats timeout, Go only acts when not mid-stage.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DISP_RUN, S_ERROR: if (go_rise) state_n = S_LOAD_GUARD;
            S_LOAD_GUARD: if (guard_cnt == GUARD_LAST) state_n = S_LOAD_START;
            S_LOAD_START: state_n = S_LOAD_RUN;
            S_LOAD_RUN: begin
                if (Load_stop)                        state_n = S_M1_GUARD;
                else if (run_inc == TIMEOUT_CYCLES)   state_n = S_ERROR;
            end
            S_M1_GUARD:   if (guard_cnt == GUARD_LAST) state_n = S_M1_START;
            S_M1_START:   state_n = S_M1_RUN;
            S_M1_RUN: begin
                if (M1_stop)                          state_n = S_DISP_GUARD;
                else if (run_inc == TIMEOUT_CYCLES)   state_n = S_ERROR;
            end
            S_DISP_GUARD: if (guard_cnt == GUARD_LAST) state_n = S_DISP_START;
            S_DISP_START: state_n = S_DISP_RUN;
            default:      state_n = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; outputs are loaded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state             <= S_IDLE;
            go_q              <= 1'b1;  // a Go level held through reset is not an edge
            guard_cnt         <= '0;
            run_cnt           <= '0;
            Load_start        <= 1'b0;
            M1_start          <= 1'b0;
            Disp_start        <= 1'b0;
            Stage             <= 2'd0;
            Error             <= 1'b0;
            Last_stage_cycles <= '0;
        end else begin
            state      <= state_n;
            go_q       <= Go;
            Load_start <= (state_n == S_LOAD_START);
            M1_start   <= (state_n == S_M1_START);
            Disp_start <= (state_n == S_DISP_START);
            Stage      <= stage_of(state_n);
            Error      <= (state_n == S_ERROR);
            if (state_n != state)  guard_cnt <= '0;
            else if (in_guard)     guard_cnt <= guard_cnt + 1'b1;
            if (state_n != state)  run_cnt <= '0;
            else if (in_run)       run_cnt <= run_inc;
            if (stop_seen)         Last_stage_cycles <= run_inc;
        end
    end

    // SRAM owner mux straight from the state register; guard, idle and error are write-inhibited.
    always_comb begin
        bus = '{addr: 18'd0, wdata: 16'd0, we_n: 1'b1};
        case (state)
            S_LOAD_START, S_LOAD_RUN: bus = '{addr: Load_address, wdata: Load_write_data, we_n: Load_we_n};
            S_M1_START, S_M1_RUN:     bus = '{addr: M1_address, wdata: M1_write_data, we_n: M1_we_n};
            S_DISP_START, S_DISP_RUN: bus = '{addr: Disp_address, wdata: 16'd0, we_n: 1'b1};
            default:                  bus = '{addr: 18'd0, wdata: 16'd0, we_n: 1'b1};
        endcase
    end

    assign SRAM_address    = bus.addr;
    assign SRAM_write_data = bus.wdata;
    assign SRAM_we_n       = bus.we_n;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Bench for sram_stage_sequencer: mux vectors from a table, hand-written
// multi-cycle sequences, and a queue of expected stage cycle counts.
module tb_sram_stage_sequencer;

    localparam logic [31:0] TO    = 32'd20;
    localparam int          GUARD = 2;
    localparam int          NV    = 8;

    localparam logic [17:0] LA_DEF = 18'h0AAAA;
    localparam logic [17:0] MA_DEF = 18'h0F0F0;
    localparam logic [17:0] DA_DEF = 18'h00F00;

    logic        Clock = 1'b0;
    logic        Resetn, Go;
    logic        Load_start, M1_start, Disp_start;
    logic        Load_stop, M1_stop;
    logic [17:0] Load_address, M1_address, Disp_address;
    logic [15:0] Load_write_data, M1_write_data;
    logic        Load_we_n, M1_we_n;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [1:0]  Stage;
    logic        Error;
    logic [31:0] Last_stage_cycles;

    sram_stage_sequencer #(.TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GUARD)) dut (
        .Clock(Clock), .Resetn(Resetn), .Go(Go),
        .Load_start(Load_start), .M1_start(M1_start), .Disp_start(Disp_start),
        .Load_stop(Load_stop), .M1_stop(M1_stop),
        .Load_address(Load_address), .M1_address(M1_address), .Disp_address(Disp_address),
        .Load_write_data(Load_write_data), .M1_write_data(M1_write_data),
        .Load_we_n(Load_we_n), .M1_we_n(M1_we_n),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .Stage(Stage), .Error(Error), .Last_stage_cycles(Last_stage_cycles)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  stg;
        logic [17:0] la;  logic [15:0] lwd; logic lwe;
        logic [17:0] ma;  logic [15:0] mwd; logic mwe;
        logic [17:0] da;
        logic [17:0] ea;  logic [15:0] ewd; logic ewe;
    } vec_t;

    vec_t vec [NV];
    int   vi = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_defaults();
        Load_address = LA_DEF; Load_write_data = 16'h5555; Load_we_n = 1'b0;
        M1_address   = MA_DEF; M1_write_data   = 16'h3C3C; M1_we_n   = 1'b0;
        Disp_address = DA_DEF;
    endtask

    function automatic logic start_of(input logic [1:0] s);
        case (s)
            2'd1:    start_of = Load_start;
            2'd2:    start_of = M1_start;
            default: start_of = Disp_start;
        endcase
    endfunction

    // Apply the next table vector, compare the muxed bus, restore default inputs.
    task automatic apply_vec();
        Load_address = vec[vi].la; Load_write_data = vec[vi].lwd; Load_we_n = vec[vi].lwe;
        M1_address   = vec[vi].ma; M1_write_data   = vec[vi].mwd; M1_we_n   = vec[vi].mwe;
        Disp_address = vec[vi].da;
        #1;
        check("mux_addr", SRAM_address, vec[vi].ea);
        check("mux_wdata", SRAM_write_data, vec[vi].ewd);
        check("mux_we_n", SRAM_we_n, vec[vi].ewe);
        vi++;
        set_defaults();
    endtask

    // First call edge enters the guard; GUARD idle cycles, then the one-cycle start.
    task automatic guard_then_start(input logic [1:0] stg);
        for (int g = 0; g < GUARD; g++) begin
            cyc();
            check("guard_stage", Stage, stg);
            check("guard_we_n", SRAM_we_n, 1);
            check("guard_addr", SRAM_address, 0);
            check("guard_start_low", start_of(stg), 0);
            check("guard_error", Error, 0);
        end
        cyc();
        check("start_pulse", start_of(stg), 1);
        check("start_stage", Stage, stg);
        check("start_bus_addr", SRAM_address, (stg == 2'd1) ? LA_DEF : (stg == 2'd2) ? MA_DEF : DA_DEF);
        check("start_bus_we_n", SRAM_we_n, (stg == 2'd3));
    endtask

    // From the START cycle: n RUN cycles, stop raised in RUN cycle n.
    task automatic run_until_stop(input logic [1:0] stg, input int n);
        for (int i = 1; i <= n; i++) begin
            cyc();
            check("run_stage", Stage, stg);
            if (vi < NV && vec[vi].stg == stg) apply_vec();
            if (i == n) begin
                if (stg == 2'd1) Load_stop = 1'b1;
                else             M1_stop   = 1'b1;
                exp_q.push_back(n);
            end
        end
    endtask

    // Scoreboard pop on stage hand-over, plus single-cycle start pulse checks.
    logic [1:0] prev_stage;
    logic       p_ls, p_ms, p_ds;
    always @(negedge Clock) begin
        if (Resetn === 1'b1 && ((prev_stage == 2'd1 && Stage == 2'd2) || (prev_stage == 2'd2 && Stage == 2'd3))) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_underflow: stage %0d->%0d with nothing expected", prev_stage, Stage);
            end else begin
                check("last_stage_cycles", Last_stage_cycles, exp_q.pop_front());
            end
        end
        if (Load_start === 1'b1) check("load_start_width", p_ls, 0);
        if (M1_start === 1'b1)   check("m1_start_width", p_ms, 0);
        if (Disp_start === 1'b1) check("disp_start_width", p_ds, 0);
        prev_stage <= Stage;
        p_ls <= Load_start; p_ms <= M1_start; p_ds <= Disp_start;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{stg:2'd1, la:18'h12345, lwd:16'hBEEF, lwe:1'b0, ma:18'h00ABC, mwd:16'h1111, mwe:1'b0, da:18'h3FFFF, ea:18'h12345, ewd:16'hBEEF, ewe:1'b0};
        vec[1] = '{stg:2'd1, la:18'h00000, lwd:16'h0000, lwe:1'b1, ma:18'h3FFFF, mwd:16'hFFFF, mwe:1'b0, da:18'h00001, ea:18'h00000, ewd:16'h0000, ewe:1'b1};
        vec[2] = '{stg:2'd1, la:18'h3FFFF, lwd:16'hFFFF, lwe:1'b0, ma:18'h00001, mwd:16'h0001, mwe:1'b1, da:18'h00000, ea:18'h3FFFF, ewd:16'hFFFF, ewe:1'b0};
        vec[3] = '{stg:2'd2, la:18'h12345, lwd:16'hBEEF, lwe:1'b0, ma:18'h2A5A5, mwd:16'h5A5A, mwe:1'b0, da:18'h00000, ea:18'h2A5A5, ewd:16'h5A5A, ewe:1'b0};
        vec[4] = '{stg:2'd2, la:18'h3FFFF, lwd:16'h0F0F, lwe:1'b0, ma:18'h00001, mwd:16'h8000, mwe:1'b1, da:18'h3FFFF, ea:18'h00001, ewd:16'h8000, ewe:1'b1};
        vec[5] = '{stg:2'd3, la:18'h12345, lwd:16'hBEEF, lwe:1'b0, ma:18'h2A5A5, mwd:16'h1234, mwe:1'b0, da:18'h3FFFF, ea:18'h3FFFF, ewd:16'h0000, ewe:1'b1};
        vec[6] = '{stg:2'd3, la:18'h00001, lwd:16'h0001, lwe:1'b0, ma:18'h00002, mwd:16'h0002, mwe:1'b0, da:18'h00000, ea:18'h00000, ewd:16'h0000, ewe:1'b1};
        vec[7] = '{stg:2'd3, la:18'h2AAAA, lwd:16'hFFFF, lwe:1'b0, ma:18'h15555, mwd:16'hFFFF, mwe:1'b0, da:18'h15555, ea:18'h15555, ewd:16'h0000, ewe:1'b1};

        // Reset state, with live write requests on the stage buses.
        Resetn = 1'b0; Go = 1'b0; Load_stop = 1'b0; M1_stop = 1'b0;
        set_defaults();
        #12;
        check("rst_stage", Stage, 0);
        check("rst_error", Error, 0);
        check("rst_last", Last_stage_cycles, 0);
        check("rst_starts", {Load_start, M1_start, Disp_start}, 0);
        check("rst_we_n", SRAM_we_n, 1);
        check("rst_addr", SRAM_address, 0);
        check("rst_wdata", SRAM_write_data, 0);
        cyc(); cyc();
        Resetn = 1'b1;
        cyc(); cyc();
        check("idle_stage", Stage, 0);
        check("idle_no_start", Load_start, 0);

        // Run 1: load stops at RUN cycle 10, M1 at RUN cycle 7, display runs on.
        Go = 1'b1;
        guard_then_start(2'd1);
        Go = 1'b0;
        run_until_stop(2'd1, 10);
        guard_then_start(2'd2);
        Load_stop = 1'b0;
        run_until_stop(2'd2, 7);   // M1_stop stays high afterwards
        guard_then_start(2'd3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("disp_stage", Stage, 3);
            apply_vec();
        end
        repeat (30) cyc();
        check("disp_no_timeout_stage", Stage, 3);
        check("disp_no_timeout_error", Error, 0);

        // Run 2: restart from display; stop and timeout coincide; stale M1 stop.
        Go = 1'b1;
        guard_then_start(2'd1);
        Go = 1'b0;
        run_until_stop(2'd1, 20);
        guard_then_start(2'd2);
        check("coincide_error", Error, 0);
        Load_stop = 1'b0;
        run_until_stop(2'd2, 1);
        guard_then_start(2'd3);
        M1_stop = 1'b0;
        cyc();

        // Run 3: load hangs -> timeout after 20 RUN cycles, then Go recovers.
        Go = 1'b1;
        guard_then_start(2'd1);
        Go = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("to_run_stage", Stage, 1);
            check("to_run_error", Error, 0);
        end
        cyc();
        check("to_error", Error, 1);
        check("to_stage", Stage, 0);
        check("to_we_n", SRAM_we_n, 1);
        check("to_last_hold", Last_stage_cycles, 1);
        repeat (3) cyc();
        check("to_error_held", Error, 1);
        Go = 1'b1;
        guard_then_start(2'd1);
        Go = 1'b0;
        run_until_stop(2'd1, 3);
        guard_then_start(2'd2);
        Load_stop = 1'b0;
        repeat (3) begin
            cyc();
            check("m1_run_stage", Stage, 2);
        end
        check("m1_we_n_live", SRAM_we_n, 0);

        // Asynchronous reset mid M1_RUN with Go held high through it.
        Go = 1'b1;
        #2;
        Resetn = 1'b0;
        #1;
        check("arst_we_n", SRAM_we_n, 1);
        check("arst_addr", SRAM_address, 0);
        check("arst_stage", Stage, 0);
        check("arst_last", Last_stage_cycles, 0);
        cyc(); cyc();
        Resetn = 1'b1;
        repeat (6) begin
            cyc();
            check("post_rst_stage", Stage, 0);
            check("post_rst_no_start", Load_start, 0);
        end
        Go = 1'b0;
        cyc();
        Go = 1'b1;
        guard_then_start(2'd1);
        Go = 1'b0;
        cyc();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_stage_sequencer.md
# sram_stage_sequencer

Top-level sequencer and SRAM owner arbiter for the image pipeline. Runs the stages in fixed order: UART image load, then M1 colourspace conversion, then VGA display. Gives exactly one stage the external SRAM bus at a time, with a write-inhibited guard gap between owners. Also issues each stage's Start pulse, waits for its Stop, times out hung stages and reports per-stage cycle counts.

## Interface
- TIMEOUT_CYCLES, 32'd50_000_000, maximum RUN cycles for LOAD or M1 before ERROR (1 s at 50 MHz)
- GUARD_CYCLES, 2, idle SRAM cycles inserted before each ownership change (≥1)
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  asynchronous, active-low reset
- Go  in  1  debounced push-button level; rising edge starts or restarts the sequence
- Load_start / M1_start / Disp_start  out  1  one-cycle start pulses to the stages
- Load_stop / M1_stop  in  1  stage-done levels (may stay high after completion)
- Load_address, M1_address, Disp_address  in  18  per-stage SRAM address
- Load_write_data, M1_write_data  in  16  per-stage write data
- Load_we_n, M1_we_n  in  1  per-stage active-low write enable
- SRAM_address  out  18; SRAM_write_data  out  16; SRAM_we_n  out  1  muxed SRAM bus
- Stage  out  2  0 = idle/error, 1 = load, 2 = M1, 3 = display
- Error  out  1  set on timeout
- Last_stage_cycles  out  32  RUN length of the most recently completed stage

## Operation
- States: IDLE, LOAD_GUARD, LOAD_START, LOAD_RUN, M1_GUARD, M1_START, M1_RUN, DISP_GUARD, DISP_START, DISP_RUN, ERROR.
- Go edge detection: a registered copy of Go. go_rise = Go & ~Go_q. A Go held high across reset does not produce an edge.
- IDLE: on go_rise go to LOAD_GUARD.
- Transitions from DISP_RUN and ERROR:
  - DISP_RUN: on go_rise go to LOAD_GUARD.
  - ERROR: on go_rise go to LOAD_GUARD and clear Error.
- X_GUARD: hold for GUARD_CYCLES cycles (guard counter), then go to X_START.
- X_START: lasts 1 cycle. X_start = 1 in this cycle only. Then go to X_RUN.
- RUN counter behaviour:
  - Cleared on entry to RUN.
  - Increments every RUN cycle.
  - Saturates at 2^32−1.
- LOAD_RUN / M1_RUN exit conditions:
  - If X_stop = 1: Last_stage_cycles ← counter+1, then go to the next stage's GUARD (LOAD→M1_GUARD, M1→DISP_GUARD).
  - Otherwise, if counter+1 == TIMEOUT_CYCLES: set Error, go to ERROR.
  - Stop and timeout in the same cycle: stop wins.
- X_stop is ignored outside X_RUN. A stale high Stop from a previous run has no effect before the new Start.
- DISP_RUN never ends on its own. It has no timeout.
- go_rise in LOAD/M1 GUARD, START or RUN is ignored.
- SRAM mux (combinational from state):
  - LOAD_START and LOAD_RUN: the Load_* bus.
  - M1_START and M1_RUN: the M1_* bus.
  - DISP_START and DISP_RUN: Disp_address, with write_data = 0 and we_n = 1.
  - Every other state: address 0, write_data 0, we_n 1.
- SRAM_read_data is routed to all stages outside this block.
- Stage output: 1 in the LOAD_* states, 2 in the M1_* states, 3 in the DISP_* states, 0 otherwise.

## Timing
- Reset values: state IDLE, all *_start 0, Stage 0, Error 0, Last_stage_cycles 0, counters 0.
  - SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1.
  - These apply asynchronously while Resetn is low, including mid-run. This blocks partial writes.
- Start pulses, Stage, Error and Last_stage_cycles are registered.
- SRAM outputs are combinational from the state register. There are 0 cycles of mux latency after a state change.
- Latency from go_rise to Load_start: GUARD_CYCLES+1 cycles. With the default GUARD_CYCLES = 2, Load_start is high 3 cycles after the cycle in which go_rise is seen.
- Latency from stop sampled to the next stage's Start: GUARD_CYCLES+1 cycles. SRAM_we_n is 1 throughout the gap.
- Stop is sampled at the first RUN cycle at the earliest, i.e. 1 cycle after the Start pulse. A stage that asserts Stop in that first cycle gives Last_stage_cycles = 1.

## Test plan
- Reset, one Go pulse; Load_stop high at RUN cycle 10; M1_stop high at RUN cycle 7 → Load_start, M1_start and Disp_start each a single-cycle pulse; Last_stage_cycles = 10, then 7; Stage steps 1→2→3; SRAM_we_n = 1 in every guard cycle.
- Mux check: in LOAD_RUN drive Load_address = 18'h12345, Load_we_n = 0, and M1_we_n = 0 with a different address → SRAM bus shows only the Load values. In DISP_RUN, Disp_address = 18'h3FFFF gives SRAM_we_n = 1.
- Stale stop: M1_stop held high before M1_START → no transition until the M1_RUN first cycle; Last_stage_cycles = 1.
- Timeout with TIMEOUT_CYCLES = 20 and Load_stop held 0 → ERROR after 20 RUN cycles; Error = 1, Stage = 0, SRAM_we_n = 1. A Go edge then clears Error and restarts LOAD.
- Stop and timeout coincide (Load_stop high at RUN cycle 20, TIMEOUT 20) → move to M1_GUARD, Error stays 0.
- Resetn low in M1_RUN with M1_we_n = 0 → SRAM_we_n = 1 immediately; after release, state IDLE and no start pulse until a new Go edge. A Go held high through reset does not restart the sequence.
